// File: rtl/bit_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bit_word_bridge
// Brief    : Bidirectional serial-bit <-> WIDTH-bit word bridge with
//            valid/ready handshakes; independent RX (assemble) and TX
//            (serialise) paths, both at full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module bit_word_bridge #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    // RX: bits in, words out
    input  logic                     in_bit,
    input  logic                     in_bit_valid,
    output logic                     in_bit_ready,
    output logic [WIDTH-1:0]         out_word,
    output logic                     out_word_valid,
    input  logic                     out_word_ready,
    output logic [$clog2(WIDTH)-1:0] rx_count,
    // TX: words in, bits out
    input  logic [WIDTH-1:0]         in_word,
    input  logic                     in_word_valid,
    output logic                     in_word_ready,
    output logic                     out_bit,
    output logic                     out_bit_valid,
    input  logic                     out_bit_ready
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_word;
    logic               r_word_valid;
    logic [WIDTH-1:0]   w_shift_next;
    logic [c_CNT_W-1:0] w_pos;
    logic               w_rx_last;
    logic               w_bit_take;
    logic               w_pop;

    assign w_rx_last  = (r_cnt == c_LAST);
    assign w_pop      = r_word_valid & out_word_ready;
    // Only the completing bit can stall, and only while the holding register is full.
    assign in_bit_ready = ~w_rx_last | ~r_word_valid | out_word_ready;
    assign w_bit_take = in_bit_valid & in_bit_ready;
    assign w_pos      = MSB_FIRST ? (c_LAST - r_cnt) : r_cnt;

    always_comb begin
        w_shift_next = r_shift;
        if (w_bit_take) begin
            w_shift_next[w_pos] = in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            if (flush) begin
                r_cnt <= '0;
                if (w_pop) begin
                    r_word_valid <= 1'b0;
                end
            end else if (w_bit_take && w_rx_last) begin
                r_word       <= w_shift_next;
                r_word_valid <= 1'b1;
                r_cnt        <= '0;
            end else begin
                if (w_bit_take) begin
                    r_cnt <= r_cnt + c_ONE;
                end
                if (w_pop) begin
                    r_word_valid <= 1'b0;
                end
            end
        end
    end

    assign out_word       = r_word;
    assign out_word_valid = r_word_valid;
    assign rx_count       = r_cnt;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } tx_state_t;

    tx_state_t          r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [c_CNT_W-1:0] r_bidx;
    logic               r_bit_valid;
    logic [WIDTH-1:0]   w_sr_shifted;
    logic               w_tx_last;

    assign w_tx_last     = (r_bidx == c_LAST);
    assign in_word_ready = (r_state == S_IDLE) | (out_bit_ready & w_tx_last);
    // The outgoing bit always sits at the register end, so out_bit comes straight from a flop.
    assign w_sr_shifted  = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    assign out_bit       = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    assign out_bit_valid = r_bit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_bidx      <= '0;
            r_bit_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_word_valid) begin
                        r_sr        <= in_word;
                        r_bidx      <= '0;
                        r_bit_valid <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (out_bit_ready) begin
                        if (w_tx_last) begin
                            if (in_word_valid) begin
                                r_sr   <= in_word;
                                r_bidx <= '0;
                            end else begin
                                r_bit_valid <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_sr   <= w_sr_shifted;
                            r_bidx <= r_bidx + c_ONE;
                        end
                    end
                end
                default: begin
                    r_bit_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_word_bridge
// Brief    : Two bridges (LSB-first and MSB-first) on shared stimulus, checked
//            each cycle against a word/bit-count model plus literal vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_word_bridge;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_bit_valid = 1'b0;
    logic       out_word_ready = 1'b0;
    logic [7:0] in_word = 8'h00;
    logic       in_word_valid = 1'b0;
    logic       out_bit_ready = 1'b0;

    logic       in_bit_ready   [2];
    logic [7:0] out_word       [2];
    logic       out_word_valid [2];
    logic [2:0] rx_count       [2];
    logic       in_word_ready  [2];
    logic       out_bit        [2];
    logic       out_bit_valid  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_word_bridge #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_bit(in_bit), .in_bit_valid(in_bit_valid), .in_bit_ready(in_bit_ready[0]),
        .out_word(out_word[0]), .out_word_valid(out_word_valid[0]),
        .out_word_ready(out_word_ready), .rx_count(rx_count[0]),
        .in_word(in_word), .in_word_valid(in_word_valid), .in_word_ready(in_word_ready[0]),
        .out_bit(out_bit[0]), .out_bit_valid(out_bit_valid[0]), .out_bit_ready(out_bit_ready)
    );

    bit_word_bridge #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_bit(in_bit), .in_bit_valid(in_bit_valid), .in_bit_ready(in_bit_ready[1]),
        .out_word(out_word[1]), .out_word_valid(out_word_valid[1]),
        .out_word_ready(out_word_ready), .rx_count(rx_count[1]),
        .in_word(in_word), .in_word_valid(in_word_valid), .in_word_ready(in_word_ready[1]),
        .out_bit(out_bit[1]), .out_bit_valid(out_bit_valid[1]), .out_bit_ready(out_bit_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bits collected so far, the held word, and how many TX bits remain.
    int         m_rx_n    [2];
    logic [7:0] m_rx_acc  [2];
    logic [7:0] m_word    [2];
    logic       m_word_v  [2];
    logic [7:0] m_tx_word [2];
    int         m_tx_left [2];

    function automatic int order(input int i, input int k);
        return (i == 1) ? (W - 1 - k) : k;
    endfunction

    function automatic logic m_bit_rdy(input int i);
        return !(m_rx_n[i] == W - 1 && m_word_v[i] && !out_word_ready);
    endfunction

    function automatic logic m_word_rdy(input int i);
        return (m_tx_left[i] == 0) || (out_bit_ready && m_tx_left[i] == 1);
    endfunction

    function automatic logic [7:0] put_bit(input logic [7:0] acc, input int pos, input logic b);
        return acc | (8'(b) << pos);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_rx_n[i]    <= 0;
                m_rx_acc[i]  <= 8'h00;
                m_word[i]    <= 8'h00;
                m_word_v[i]  <= 1'b0;
                m_tx_word[i] <= 8'h00;
                m_tx_left[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flush) begin
                    m_rx_n[i]   <= 0;
                    m_rx_acc[i] <= 8'h00;
                    if (m_word_v[i] && out_word_ready) m_word_v[i] <= 1'b0;
                end else if (in_bit_valid && m_bit_rdy(i)) begin
                    if (m_rx_n[i] == W - 1) begin
                        m_word[i]   <= put_bit(m_rx_acc[i], order(i, m_rx_n[i]), in_bit);
                        m_word_v[i] <= 1'b1;
                        m_rx_n[i]   <= 0;
                        m_rx_acc[i] <= 8'h00;
                    end else begin
                        m_rx_acc[i] <= put_bit(m_rx_acc[i], order(i, m_rx_n[i]), in_bit);
                        m_rx_n[i]   <= m_rx_n[i] + 1;
                        if (m_word_v[i] && out_word_ready) m_word_v[i] <= 1'b0;
                    end
                end else if (m_word_v[i] && out_word_ready) begin
                    m_word_v[i] <= 1'b0;
                end

                if (in_word_valid && m_word_rdy(i)) begin
                    m_tx_word[i] <= in_word;
                    m_tx_left[i] <= W;
                end else if (m_tx_left[i] > 0 && out_bit_ready) begin
                    m_tx_left[i] <= m_tx_left[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d out_word", i), out_word[i], m_word[i]);
            chk($sformatf("u%0d out_word_valid", i), out_word_valid[i], m_word_v[i]);
            chk($sformatf("u%0d rx_count", i), rx_count[i], m_rx_n[i]);
            chk($sformatf("u%0d in_bit_ready", i), in_bit_ready[i], m_bit_rdy(i));
            chk($sformatf("u%0d in_word_ready", i), in_word_ready[i], m_word_rdy(i));
            chk($sformatf("u%0d out_bit_valid", i), out_bit_valid[i], m_tx_left[i] > 0);
            if (m_tx_left[i] > 0)
                chk($sformatf("u%0d out_bit", i), out_bit[i],
                    m_tx_word[i][order(i, W - m_tx_left[i])]);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        in_bit       = b;
        in_bit_valid = 1'b1;
        while (!in_bit_ready[0] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_bit timeout: in_bit_ready stuck at 0, wanted 1");
        end
        tick();
        in_bit_valid = 1'b0;
    endtask

    task automatic rx_word(input logic [7:0] w);
        for (int k = 0; k < W; k++) send_bit(w[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq0;
        logic [15:0] seq1;
        logic [15:0] rmask;
        logic [3:0]  tail;
        logic [7:0]  got;
        logic [7:0]  v4d;

        // Reset values while rst_n is held low
        #2;
        chk("rst out_word", out_word[0], 8'h00);
        chk("rst out_word_valid", out_word_valid[0], 1'b0);
        chk("rst rx_count", rx_count[0], 3'd0);
        chk("rst out_bit", out_bit[1], 1'b0);
        chk("rst out_bit_valid", out_bit_valid[1], 1'b0);
        chk("rst in_bit_ready", in_bit_ready[0], 1'b1);
        chk("rst in_word_ready", in_word_ready[1], 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // RX: bits 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first)
        out_word_ready = 1'b1;
        v4d = 8'b0100_1101;
        for (int k = 0; k < W; k++) send_bit(v4d[k]);
        chk("rx 4D word", out_word[0], 8'h4D);
        chk("rx B2 word msb", out_word[1], 8'hB2);
        chk("rx 4D valid", out_word_valid[0], 1'b1);
        tick();
        chk("rx 4D valid one cycle", out_word_valid[0], 1'b0);

        // RX backpressure: A5 then 3C with the consumer stalled
        out_word_ready = 1'b0;
        rx_word(8'hA5);
        for (int k = 0; k < W - 1; k++) send_bit(1'(8'h3C >> k));
        in_bit       = 1'b0;
        in_bit_valid = 1'b1;
        chk("bp ready low at bit16", in_bit_ready[0], 1'b0);
        chk("bp held A5", out_word[0], 8'hA5);
        tick();
        chk("bp rx_count 7", rx_count[0], 3'd7);
        out_word_ready = 1'b1;
        #1;
        chk("bp ready after pop", in_bit_ready[0], 1'b1);
        tick();
        in_bit_valid = 1'b0;
        chk("bp 3C word", out_word[0], 8'h3C);
        chk("bp 3C valid", out_word_valid[1], 1'b1);
        tick();
        chk("bp drained", out_word_valid[0], 1'b0);

        // RX flush at rx_count=5 with a word held
        out_word_ready = 1'b0;
        rx_word(8'h96);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("flush pre count", rx_count[0], 3'd5);
        flush        = 1'b1;
        in_bit       = 1'b1;
        in_bit_valid = 1'b1;
        tick();
        flush        = 1'b0;
        in_bit_valid = 1'b0;
        chk("flush count 0", rx_count[0], 3'd0);
        chk("flush held word", out_word[0], 8'h96);
        chk("flush held word msb", out_word[1], 8'h69);
        for (int k = 0; k < W - 1; k++) send_bit(1'(8'h5A >> k));
        out_word_ready = 1'b1;
        send_bit(1'b0);
        chk("flush fresh 5A", out_word[0], 8'h5A);
        out_word_ready = 1'b0;
        tick();

        // TX back-to-back C3, 81
        out_bit_ready = 1'b1;
        in_word       = 8'hC3;
        in_word_valid = 1'b1;
        seq0 = '0; seq1 = '0; rmask = '0;
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) rmask[15 - c] = in_word_ready[1];
            if (c >= 1) begin
                seq0[16 - c] = out_bit[0];
                seq1[16 - c] = out_bit[1];
                chk("tx b2b valid", out_bit_valid[1], 1'b1);
            end
            tick();
            if (c == 0) in_word = 8'h81;
            if (c == 8) in_word_valid = 1'b0;
        end
        chk("tx b2b msb seq", seq1, 16'hC381);
        chk("tx b2b lsb seq", seq0, 16'hC381);
        chk("tx b2b ready mask", rmask, 16'h8080);
        chk("tx b2b idle after", out_bit_valid[1], 1'b0);

        // TX stall at bidx=4
        in_word       = 8'hBC;
        in_word_valid = 1'b1;
        tick();
        in_word_valid = 1'b0;
        repeat (4) tick();
        out_bit_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall bit msb", out_bit[1], 1'b1);
            chk("stall bit lsb", out_bit[0], 1'b1);
            chk("stall valid", out_bit_valid[1], 1'b1);
            chk("stall word ready", in_word_ready[1], 1'b0);
            tick();
        end
        out_bit_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tail[3 - k] = out_bit[1];
            tick();
        end
        chk("stall tail msb", tail, 4'b1100);
        tick();

        // Reset mid-word on both paths
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        in_word       = 8'h5A;
        in_word_valid = 1'b1;
        tick();
        in_word_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst out_word_valid", out_word_valid[0], 1'b0);
        chk("midrst out_word", out_word[0], 8'h00);
        chk("midrst rx_count", rx_count[1], 3'd0);
        chk("midrst out_bit_valid", out_bit_valid[0], 1'b0);
        chk("midrst out_bit", out_bit[1], 1'b0);
        chk("midrst in_word_ready", in_word_ready[0], 1'b1);
        chk("midrst in_bit_ready", in_bit_ready[1], 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        out_word_ready = 1'b1;
        rx_word(8'hE7);
        chk("post rst rx word", out_word[0], 8'hE7);
        in_word       = 8'h96;
        in_word_valid = 1'b1;
        tick();
        in_word_valid = 1'b0;
        got = '0;
        for (int k = 0; k < W; k++) begin
            got[k] = out_bit[0];
            tick();
        end
        chk("post rst tx word", got, 8'h96);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
